// File: rtl/yutorina_muldiv.sv
// Iterative radix-2 multiply/divide unit: one bit per clock, valid/ready on both sides.
// Shift-add multiply and restoring divide share one 2*WIDTH accumulator.
module yutorina_muldiv #(
  parameter  int WIDTH = 32,
  localparam int CNT_W = $clog2(WIDTH) + 1
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             flush,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [2:0]       op,
  input  logic [WIDTH-1:0] lhs,
  input  logic [WIDTH-1:0] rhs,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] out
);

  localparam logic [1:0] ST_IDLE = 2'd0;
  localparam logic [1:0] ST_CALC = 2'd1;
  localparam logic [1:0] ST_DONE = 2'd2;

  logic [1:0]         state;
  logic [CNT_W-1:0]   cnt;
  logic [2:0]         op_r;
  logic [2*WIDTH-1:0] acc;
  logic [WIDTH-1:0]   mag;
  logic               neg_a;
  logic               neg_b;

  logic               accept;
  logic               last_iter;
  logic               op_signed;
  logic               in_neg_a;
  logic               in_neg_b;
  logic [WIDTH-1:0]   lhs_mag;
  logic [WIDTH-1:0]   rhs_mag;
  logic               is_div;
  logic [WIDTH:0]     add_sum;
  logic [WIDTH:0]     trial;
  logic [2*WIDTH-1:0] mul_next;
  logic [2*WIDTH-1:0] div_next;
  logic [2*WIDTH-1:0] acc_next;
  logic [2*WIDTH-1:0] prod_signed;
  logic [WIDTH-1:0]   quo;
  logic [WIDTH-1:0]   rem;
  logic [WIDTH-1:0]   result;

  assign in_ready  = (state == ST_IDLE);
  assign out_valid = (state == ST_DONE);
  assign accept    = in_valid && in_ready && !flush;
  assign last_iter = (cnt == CNT_W'(WIDTH - 1));

  // Only MULH, DIV and REM treat their operands as two's complement.
  assign op_signed = (op == 3'd1) || (op == 3'd3) || (op == 3'd5);
  assign in_neg_a  = op_signed && lhs[WIDTH-1];
  assign in_neg_b  = op_signed && rhs[WIDTH-1];
  assign lhs_mag   = in_neg_a ? -lhs : lhs;
  assign rhs_mag   = in_neg_b ? -rhs : rhs;
  assign is_div    = (op_r >= 3'd3) && (op_r != 3'd7);

  // Multiply keeps the multiplier in the low half and shifts the partial sum in from the top;
  // divide keeps the remainder high and shifts dividend bits out of the low half as quotient bits enter.
  always_comb begin
    add_sum  = {1'b0, acc[2*WIDTH-1:WIDTH]} + {1'b0, (acc[0] ? mag : {WIDTH{1'b0}})};
    mul_next = {add_sum, acc[WIDTH-1:1]};
    trial    = {acc[2*WIDTH-1:WIDTH], acc[WIDTH-1]} - {1'b0, mag};
    div_next = trial[WIDTH] ? {acc[2*WIDTH-2:0], 1'b0}
                            : {trial[WIDTH-1:0], acc[WIDTH-2:0], 1'b1};
    acc_next = is_div ? div_next : mul_next;
  end

  // Result is formed from the final iteration so it is registered on the edge entering DONE.
  always_comb begin
    prod_signed = (neg_a ^ neg_b) ? -acc_next : acc_next;
    quo         = acc_next[WIDTH-1:0];
    rem         = acc_next[2*WIDTH-1:WIDTH];
    result      = '0;
    case (op_r)
      3'd0:       result = acc_next[WIDTH-1:0];
      3'd1:       result = prod_signed[2*WIDTH-1:WIDTH];
      3'd2:       result = acc_next[2*WIDTH-1:WIDTH];
      3'd3, 3'd4: result = (mag == '0) ? {WIDTH{1'b1}} : ((neg_a ^ neg_b) ? -quo : quo);
      3'd5, 3'd6: result = neg_a ? -rem : rem;
      default:    result = '0;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state <= ST_IDLE;
      cnt   <= '0;
      op_r  <= '0;
      acc   <= '0;
      mag   <= '0;
      neg_a <= 1'b0;
      neg_b <= 1'b0;
      out   <= '0;
    end else if (flush) begin
      state <= ST_IDLE;
    end else begin
      case (state)
        ST_IDLE: begin
          if (accept) begin
            op_r  <= op;
            neg_a <= in_neg_a;
            neg_b <= in_neg_b;
            cnt   <= '0;
            state <= ST_CALC;
            if ((op >= 3'd3) && (op != 3'd7)) begin
              acc <= {{WIDTH{1'b0}}, lhs_mag};
              mag <= rhs_mag;
            end else begin
              acc <= {{WIDTH{1'b0}}, rhs_mag};
              mag <= lhs_mag;
            end
          end
        end
        ST_CALC: begin
          acc <= acc_next;
          if (cnt != {CNT_W{1'b1}}) cnt <= cnt + 1'b1;
          if (last_iter) begin
            out   <= result;
            state <= ST_DONE;
          end
        end
        ST_DONE: begin
          if (out_ready) state <= ST_IDLE;
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_yutorina_muldiv.sv
// Directed bench for yutorina_muldiv: 32-bit vector table plus handshake/flush/reset sequences,
// and an 8-bit instance for the narrow-width case.
module tb_yutorina_muldiv;

  typedef struct {
    logic [2:0]  op;
    logic [31:0] a;
    logic [31:0] b;
    logic [31:0] exp;
  } vec_t;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        flush = 1'b0;
  logic        in_valid = 1'b0;
  logic        in_ready;
  logic [2:0]  op = '0;
  logic [31:0] lhs = '0;
  logic [31:0] rhs = '0;
  logic        out_valid;
  logic        out_ready = 1'b0;
  logic [31:0] out;

  logic        b_in_valid = 1'b0;
  logic        b_in_ready;
  logic [2:0]  b_op = '0;
  logic [7:0]  b_lhs = '0;
  logic [7:0]  b_rhs = '0;
  logic        b_out_valid;
  logic        b_out_ready = 1'b0;
  logic [7:0]  b_out;

  int total = 0;
  int bad = 0;

  vec_t vecs[18];

  always #5 clk = ~clk;

  yutorina_muldiv #(.WIDTH(32)) dut (
    .clk(clk), .reset(reset), .flush(flush),
    .in_valid(in_valid), .in_ready(in_ready), .op(op), .lhs(lhs), .rhs(rhs),
    .out_valid(out_valid), .out_ready(out_ready), .out(out)
  );

  yutorina_muldiv #(.WIDTH(8)) dut8 (
    .clk(clk), .reset(reset), .flush(1'b0),
    .in_valid(b_in_valid), .in_ready(b_in_ready), .op(b_op), .lhs(b_lhs), .rhs(b_rhs),
    .out_valid(b_out_valid), .out_ready(b_out_ready), .out(b_out)
  );

  task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("[TB] FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
    end
  endtask

  // Latency is counted in rising edges from the accept edge to the first sample with out_valid high.
  task automatic applyStimulus(input logic [2:0] o, input logic [31:0] a, input logic [31:0] b,
                               output logic [31:0] res, output int lat, output bit ready_low);
    in_valid = 1'b1;
    op = o;
    lhs = a;
    rhs = b;
    @(posedge clk); #1;
    in_valid = 1'b0;
    lhs = $urandom;
    rhs = $urandom;
    op = 3'($urandom);
    lat = 0;
    ready_low = 1'b1;
    while (!out_valid && lat < 200) begin
      if (in_ready) ready_low = 1'b0;
      @(posedge clk); #1;
      lat++;
    end
    res = out;
    out_ready = 1'b1;
    @(posedge clk); #1;
    out_ready = 1'b0;
  endtask

  initial begin
    logic [31:0] res;
    logic [31:0] held;
    int lat;
    bit ready_low;
    bit seen;
    int acc_cyc[3];
    int nacc;

    vecs[0]  = '{3'd0, 32'h0000_0007, 32'hFFFF_FFFD, 32'hFFFF_FFEB};
    vecs[1]  = '{3'd1, 32'h8000_0000, 32'h8000_0000, 32'h4000_0000};
    vecs[2]  = '{3'd2, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFE};
    vecs[3]  = '{3'd1, 32'hFFFF_FFFF, 32'h0000_0001, 32'hFFFF_FFFF};
    vecs[4]  = '{3'd3, 32'hFFFF_FFF9, 32'h0000_0002, 32'hFFFF_FFFD};
    vecs[5]  = '{3'd5, 32'hFFFF_FFF9, 32'h0000_0002, 32'hFFFF_FFFF};
    vecs[6]  = '{3'd4, 32'd100,       32'd7,         32'd14};
    vecs[7]  = '{3'd6, 32'd100,       32'd7,         32'd2};
    vecs[8]  = '{3'd4, 32'd5,         32'd0,         32'hFFFF_FFFF};
    vecs[9]  = '{3'd6, 32'd5,         32'd0,         32'd5};
    vecs[10] = '{3'd3, 32'h8000_0000, 32'hFFFF_FFFF, 32'h8000_0000};
    vecs[11] = '{3'd5, 32'h8000_0000, 32'hFFFF_FFFF, 32'h0000_0000};
    vecs[12] = '{3'd3, 32'hFFFF_FFF9, 32'h0000_0000, 32'hFFFF_FFFF};
    vecs[13] = '{3'd5, 32'hFFFF_FFF9, 32'h0000_0000, 32'hFFFF_FFF9};
    vecs[14] = '{3'd7, 32'h1234_5678, 32'h9ABC_DEF0, 32'h0000_0000};
    vecs[15] = '{3'd1, 32'hFFFF_FFFE, 32'h0000_0003, 32'hFFFF_FFFF};
    vecs[16] = '{3'd3, 32'h0000_0007, 32'hFFFF_FFFE, 32'hFFFF_FFFD};
    vecs[17] = '{3'd2, 32'h8000_0000, 32'h0000_0004, 32'h0000_0002};

    repeat (3) @(posedge clk);
    #1;
    reset = 1'b0;
    checkOutput("reset_in_ready", {31'd0, in_ready}, 32'd1);
    checkOutput("reset_out_valid", {31'd0, out_valid}, 32'd0);
    checkOutput("reset_out", out, 32'd0);
    checkOutput("reset8_out", {24'd0, b_out}, 32'd0);

    for (int i = 0; i < 18; i++) begin
      applyStimulus(vecs[i].op, vecs[i].a, vecs[i].b, res, lat, ready_low);
      checkOutput($sformatf("vec%0d_result", i), res, vecs[i].exp);
      checkOutput($sformatf("vec%0d_latency", i), 32'(lat), 32'd32);
      if (i == 0) checkOutput("vec0_in_ready_low", {31'd0, ready_low}, 32'd1);
    end

    // Backpressure: result must hold in DONE while out_ready is low.
    in_valid = 1'b1; op = 3'd4; lhs = 32'd100; rhs = 32'd7;
    @(posedge clk); #1;
    in_valid = 1'b0;
    lat = 0;
    while (!out_valid && lat < 200) begin
      @(posedge clk); #1;
      lat++;
    end
    checkOutput("bp_latency", 32'(lat), 32'd32);
    held = out;
    for (int i = 0; i < 5; i++) begin
      @(posedge clk); #1;
      checkOutput($sformatf("bp_valid_%0d", i), {31'd0, out_valid}, 32'd1);
      checkOutput($sformatf("bp_out_%0d", i), out, 32'd14);
      checkOutput($sformatf("bp_in_ready_%0d", i), {31'd0, in_ready}, 32'd0);
    end
    checkOutput("bp_hold", out, held);
    out_ready = 1'b1;
    @(posedge clk); #1;
    out_ready = 1'b0;
    checkOutput("bp_release_valid", {31'd0, out_valid}, 32'd0);
    checkOutput("bp_release_ready", {31'd0, in_ready}, 32'd1);

    // Flush at counter 10, then flush must also block an accept in IDLE.
    in_valid = 1'b1; op = 3'd0; lhs = 32'd3; rhs = 32'd5;
    @(posedge clk); #1;
    in_valid = 1'b0;
    repeat (10) begin @(posedge clk); #1; end
    flush = 1'b1;
    @(posedge clk); #1;
    checkOutput("flush_in_ready", {31'd0, in_ready}, 32'd1);
    checkOutput("flush_out_valid", {31'd0, out_valid}, 32'd0);
    in_valid = 1'b1; lhs = 32'd9; rhs = 32'd9;
    @(posedge clk); #1;
    checkOutput("flush_blocks_accept", {31'd0, in_ready}, 32'd1);
    flush = 1'b0;
    in_valid = 1'b0;
    seen = 1'b0;
    repeat (40) begin
      @(posedge clk); #1;
      if (out_valid) seen = 1'b1;
    end
    checkOutput("flush_no_result", {31'd0, seen}, 32'd0);
    applyStimulus(3'd0, 32'd3, 32'd4, res, lat, ready_low);
    checkOutput("post_flush_mul", res, 32'd12);
    checkOutput("post_flush_latency", 32'(lat), 32'd32);

    // Reset in the middle of CALC.
    in_valid = 1'b1; op = 3'd0; lhs = 32'd5; rhs = 32'd6;
    @(posedge clk); #1;
    in_valid = 1'b0;
    repeat (5) begin @(posedge clk); #1; end
    reset = 1'b1;
    @(posedge clk); #1;
    reset = 1'b0;
    checkOutput("midreset_in_ready", {31'd0, in_ready}, 32'd1);
    checkOutput("midreset_out_valid", {31'd0, out_valid}, 32'd0);
    checkOutput("midreset_out", out, 32'd0);

    // Back-to-back: in_valid and out_ready held high; accepts spaced WIDTH+2 edges.
    in_valid = 1'b1; op = 3'd0; lhs = 32'd2; rhs = 32'd3;
    out_ready = 1'b1;
    nacc = 0;
    acc_cyc = '{0, 0, 0};
    for (int c = 0; c < 150 && nacc < 3; c++) begin
      if (in_ready) begin
        acc_cyc[nacc] = c;
        nacc++;
      end
      @(posedge clk); #1;
    end
    in_valid = 1'b0;
    checkOutput("b2b_count", 32'(nacc), 32'd3);
    checkOutput("b2b_gap1", 32'(acc_cyc[1] - acc_cyc[0]), 32'd34);
    checkOutput("b2b_gap2", 32'(acc_cyc[2] - acc_cyc[1]), 32'd34);
    lat = 0;
    while (!in_ready && lat < 200) begin
      @(posedge clk); #1;
      lat++;
    end
    checkOutput("b2b_drain", {31'd0, in_ready}, 32'd1);
    out_ready = 1'b0;

    // Narrow instance: MULHU 0xFF x 0xFF.
    b_in_valid = 1'b1; b_op = 3'd2; b_lhs = 8'hFF; b_rhs = 8'hFF;
    @(posedge clk); #1;
    b_in_valid = 1'b0;
    b_lhs = 8'h00; b_rhs = 8'h00; b_op = 3'd0;
    lat = 0;
    while (!b_out_valid && lat < 100) begin
      @(posedge clk); #1;
      lat++;
    end
    checkOutput("w8_mulhu", {24'd0, b_out}, 32'h0000_00FE);
    checkOutput("w8_latency", 32'(lat), 32'd8);
    b_out_ready = 1'b1;
    @(posedge clk); #1;
    b_out_ready = 1'b0;
    checkOutput("w8_release", {31'd0, b_in_ready}, 32'd1);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
